// File: rtl/mag_sub_pipe_32_pkg.sv
// mag_sub_pipe_32_pkg: gpk encoding, default width, LZC width and prefix-combine helpers
package mag_sub_pipe_32_pkg;
    // Each gpk pair is the carry-out of a bit group as a function of its carry-in:
    // bit1 = carry-out when carry-in is 0, bit0 = carry-out when carry-in is 1.
    localparam logic [1:0] GPK_KILL = 2'b00;
    localparam logic [1:0] GPK_PROP = 2'b01;
    localparam logic [1:0] GPK_GEN  = 2'b11;
    localparam int WIDTH_DEF = 32;

    function automatic int lzc_width(input int w);
        return $clog2(w) + 1;
    endfunction

    // Composition of two adjacent groups: feed the low group's carry-out into the high group.
    function automatic logic [1:0] gpk_combine(input logic [1:0] hi, input logic [1:0] lo);
        return {lo[1] ? hi[0] : hi[1], lo[0] ? hi[0] : hi[1]};
    endfunction
endpackage

// File: rtl/gpk_prefix_stage.sv
// gpk_prefix_stage: one Kogge-Stone level over WIDTH gpk pairs at distance DIST
//   gpk_in   in   2*WIDTH  gpk pairs, pair i at [2i+1:2i]
//   gpk_out  out  2*WIDTH  pair i combined with pair i-DIST (unchanged below DIST)
module gpk_prefix_stage
    import mag_sub_pipe_32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIST  = 1
) (
    input  logic [2*WIDTH-1:0] gpk_in,
    output logic [2*WIDTH-1:0] gpk_out
);
    always_comb begin
        gpk_out = gpk_in;
        for (int i = DIST; i < WIDTH; i++)
            gpk_out[2*i +: 2] = gpk_combine(gpk_in[2*i +: 2], gpk_in[2*(i-DIST) +: 2]);
    end
endmodule

// File: rtl/mag_sub_pipe_32.sv
// mag_sub_pipe_32: two-stage pipelined |a-b| with sign and zero flags, valid/ready on both sides
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake for a, b
//   a, b                 unsigned minuend / subtrahend
//   out_valid/out_ready  output handshake for diff, a_lt_b, zero (and lzc)
//   diff                 |a-b|;  a_lt_b: a<b;  zero: a==b
//   lzc                  leading-zero count of diff, WIDTH when diff==0 (only with LZC_OUT_EN)
module mag_sub_pipe_32
    import mag_sub_pipe_32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             a_lt_b,
    output logic             zero
`ifdef LZC_OUT_EN
    ,
    output logic [lzc_width(WIDTH)-1:0] lzc
`endif
);
    localparam int LVLS    = $clog2(WIDTH);
    localparam int S1_LVLS = LVLS / 2;
    localparam int S2_LVLS = LVLS - S1_LVLS;

    logic               s1_valid_q, s1_valid_d;
    logic               s2_valid_q, s2_valid_d;
    logic [2*WIDTH-1:0] gpk_q, gpk_d;
    logic [WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               a_lt_b_q, a_lt_b_d;
    logic               zero_q, zero_d;
    logic               s2_load, in_fire, s1_adv;
    logic [2*WIDTH-1:0] raw;
    logic [2*WIDTH-1:0] s1_lvl [0:S1_LVLS];
    logic [2*WIDTH-1:0] s2_lvl [0:S2_LVLS];
    logic [WIDTH-1:0]   grp_b0, grp_b1, sum0, sum1, mag;
    logic               lt;

    // a + ~b + 1: per-bit gpk of a[k] and ~b[k]
    always_comb begin
        raw = '0;
        for (int k = 0; k < WIDTH; k++)
            raw[2*k +: 2] = (a[k] & ~b[k]) ? GPK_GEN : (a[k] ^ ~b[k]) ? GPK_PROP : GPK_KILL;
    end

    assign s1_lvl[0] = raw;
    assign s2_lvl[0] = gpk_q;

    genvar j;
    for (j = 0; j < S1_LVLS; j++) begin : g_s1
        gpk_prefix_stage #(.WIDTH(WIDTH), .DIST(1 << j)) u_lvl (
            .gpk_in (s1_lvl[j]),
            .gpk_out(s1_lvl[j+1])
        );
    end
    for (j = 0; j < S2_LVLS; j++) begin : g_s2
        gpk_prefix_stage #(.WIDTH(WIDTH), .DIST(1 << (j + S1_LVLS))) u_lvl (
            .gpk_in (s2_lvl[j]),
            .gpk_out(s2_lvl[j+1])
        );
    end

    // Group [k:0] carry-outs for carry-in 1 (a-b) and carry-in 0 (a-b-1 = ~(b-a)),
    // so one tree yields both a-b and b-a.
    always_comb begin
        grp_b0 = '0;
        grp_b1 = '0;
        for (int k = 0; k < WIDTH; k++) begin
            grp_b0[k] = s2_lvl[S2_LVLS][2*k];
            grp_b1[k] = s2_lvl[S2_LVLS][2*k+1];
        end
    end

    assign sum1 = p_q ^ {grp_b0[WIDTH-2:0], 1'b1};
    assign sum0 = p_q ^ {grp_b1[WIDTH-2:0], 1'b0};
    assign lt   = ~grp_b0[WIDTH-1];
    assign mag  = lt ? ~sum0 : sum1;

    always_comb begin
        s2_load    = !s2_valid_q || out_ready;
        in_ready   = !s1_valid_q || s2_load;
        in_fire    = in_valid && in_ready;
        s1_adv     = s1_valid_q && s2_load;
        s1_valid_d = in_ready ? in_valid : s1_valid_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        gpk_d      = in_fire ? s1_lvl[S1_LVLS] : gpk_q;
        p_d        = in_fire ? (a ^ ~b) : p_q;
        diff_d     = s1_adv ? mag : diff_q;
        a_lt_b_d   = s1_adv ? lt : a_lt_b_q;
        // Whole word propagates exactly when every bit of a matches b.
        zero_d     = s1_adv ? (s2_lvl[S2_LVLS][2*WIDTH-1 -: 2] == GPK_PROP) : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            gpk_q      <= '0;
            p_q        <= '0;
            diff_q     <= '0;
            a_lt_b_q   <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            gpk_q      <= gpk_d;
            p_q        <= p_d;
            diff_q     <= diff_d;
            a_lt_b_q   <= a_lt_b_d;
            zero_q     <= zero_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign diff      = diff_q;
    assign a_lt_b    = a_lt_b_q;
    assign zero      = zero_q;

`ifdef LZC_OUT_EN
    localparam int LZC_W = lzc_width(WIDTH);
    logic [LZC_W-1:0] lzc_q, lzc_d;
    always_comb begin
        lzc_d = lzc_q;
        if (s1_adv) begin
            lzc_d = LZC_W'(WIDTH);
            for (int k = 0; k < WIDTH; k++)
                if (mag[k]) lzc_d = LZC_W'(WIDTH - 1 - k);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lzc_q <= '0;
        else lzc_q <= lzc_d;
    end
    assign lzc = lzc_q;
`endif
endmodule

// File: tb/tb_mag_sub_pipe_32.sv
// tb_mag_sub_pipe_32: randomized self-checking bench for mag_sub_pipe_32 against an arithmetic model
module tb_mag_sub_pipe_32;
    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, a_lt_b, zero;
    logic [31:0] a, b, diff;
`ifdef LZC_OUT_EN
    logic [5:0]  lzc;
`endif

    typedef struct {
        logic [31:0] d;
        logic        lt;
        logic        z;
        int          lz;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0, n_err = 0, n_got = 0;
    logic        stall_prev = 1'b0, hold_lt, hold_z;
    logic [31:0] hold_d;

    mag_sub_pipe_32 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .a_lt_b(a_lt_b), .zero(zero)
`ifdef LZC_OUT_EN
        , .lzc(lzc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e.lt = x < y;
        e.d  = (x < y) ? y - x : x - y;
        e.z  = x == y;
        e.lz = 32;
        for (int i = 0; i < 32; i++) if (e.d[i]) e.lz = 31 - i;
        return e;
    endfunction

    task automatic cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                         input logic ordy, output logic acc);
        exp_t e;
        in_valid = iv; a = ia; b = ib; out_ready = ordy;
        #1;
        if (stall_prev) begin
            n_cmp++;
            if (out_valid !== 1'b1 || diff !== hold_d || a_lt_b !== hold_lt || zero !== hold_z) begin
                n_err++;
                $display("FAIL stall_hold: got v=%b diff=%h lt=%b z=%b, expected v=1 diff=%h lt=%b z=%b",
                         out_valid, diff, a_lt_b, zero, hold_d, hold_lt, hold_z);
            end
        end
        stall_prev = out_valid && !ordy;
        hold_d = diff; hold_lt = a_lt_b; hold_z = zero;
        acc = iv && in_ready;
        if (acc) q.push_back(model(ia, ib));
        if (out_valid && ordy) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL spurious_out: got diff=%h with nothing outstanding, expected no output", diff);
            end else begin
                e = q.pop_front();
                n_got++;
                if (diff !== e.d || a_lt_b !== e.lt || zero !== e.z) begin
                    n_err++;
                    $display("FAIL result: got diff=%h lt=%b z=%b, expected diff=%h lt=%b z=%b",
                             diff, a_lt_b, zero, e.d, e.lt, e.z);
                end
`ifdef LZC_OUT_EN
                n_cmp++;
                if (lzc !== 6'(e.lz)) begin
                    n_err++;
                    $display("FAIL lzc: got %0d, expected %0d", lzc, e.lz);
                end
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 20 && q.size() > 0; k++) cycle(1'b0, 32'd0, 32'd0, 1'b1, acc);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d items still outstanding, expected 0", q.size());
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_cmp++;
        if (out_valid !== 1'b0 || diff !== 32'd0 || a_lt_b !== 1'b0 || zero !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s: got v=%b diff=%h lt=%b z=%b in_ready=%b, expected v=0 diff=0 lt=0 z=0 in_ready=1",
                     tag, out_valid, diff, a_lt_b, zero, in_ready);
        end
`ifdef LZC_OUT_EN
        n_cmp++;
        if (lzc !== 6'd0) begin
            n_err++;
            $display("FAIL %s_lzc: got %0d, expected 0", tag, lzc);
        end
`endif
    endtask

    task automatic check_latency(input logic [31:0] ia, input logic [31:0] ib);
        logic acc;
        cycle(1'b1, ia, ib, 1'b1, acc);
        n_cmp++;
        if (acc !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_1: got acc=%b out_valid=%b after one edge, expected acc=1 out_valid=0", acc, out_valid);
        end
        cycle(1'b0, 32'd0, 32'd0, 1'b1, acc);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL latency_2: got out_valid=%b after two edges, expected 1", out_valid);
        end
        drain();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        check_latency(32'd5, 32'd3);
    endtask

    task automatic test_boundary();
        logic        acc;
        logic [31:0] va [4] = '{32'd3, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] vb [4] = '{32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, va[i], vb[i], 1'b1, acc);
            n_cmp++;
            if (acc !== 1'b1) begin
                n_err++;
                $display("FAIL boundary_accept: got acc=%b for item %0d, expected 1", acc, i);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic        acc;
        int          accepted = 0, got0 = n_got;
        logic [31:0] va [3] = '{32'd10, 32'd20, 32'd7};
        logic [31:0] vb [3] = '{32'd1, 32'd5, 32'd9};
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1, va[accepted], vb[accepted], 1'b0, acc);
            if (acc) accepted++;
        end
        n_cmp++;
        if (accepted != 2 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure: got accepted=%0d in_ready=%b, expected accepted=2 in_ready=0", accepted, in_ready);
        end
        for (int c = 0; c < 10 && accepted < 3; c++) begin
            cycle(1'b1, va[accepted], vb[accepted], 1'b1, acc);
            if (acc) accepted++;
        end
        drain();
        n_cmp++;
        if (n_got - got0 != 3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d results, expected 3", n_got - got0);
        end
    endtask

    task automatic test_stream();
        logic        acc, pend = 1'b0;
        logic [31:0] pa = '0, pb = '0;
        int          accepted = 0, cyc = 0;
        while (accepted < 100 && cyc < 2000) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pa = $urandom;
                case ($urandom_range(0, 3))
                    0: pb = pa;
                    1: pb = pa + 32'($urandom_range(0, 7)) - 32'd3;
                    default: pb = $urandom;
                endcase
            end
            cycle(pend, pa, pb, $urandom_range(0, 9) < 6, acc);
            if (acc) begin
                pend = 1'b0;
                accepted++;
            end
            cyc++;
        end
        n_cmp++;
        if (accepted != 100) begin
            n_err++;
            $display("FAIL stream_timeout: got %0d accepted, expected 100", accepted);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic acc;
        cycle(1'b1, 32'd40, 32'd2, 1'b0, acc);
        cycle(1'b1, 32'd1, 32'd50, 1'b0, acc);
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_fill: got out_valid=%b in_ready=%b, expected 1 0", out_valid, in_ready);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid");
        q.delete();
        stall_prev = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_latency(32'd100, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish within time limit, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_stream();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
